// File: rtl/speedy_inv_sbox_serial.sv
// Inverse SPEEDY 6-bit S-box layer, PER_CYCLE lanes substituted per clock.
// Valid/ready on both sides; out_data mirrors the state register at all times.
module speedy_inv_sbox_serial #(
    parameter int LANES     = 32,
    parameter int PER_CYCLE = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [6*LANES-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [6*LANES-1:0] out_data,
    output logic               busy
);

    localparam int NCYC = LANES / PER_CYCLE;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam int CHW  = 6 * PER_CYCLE;
    localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Table is stored in reversed bit order, so both index and result are flipped.
    function automatic logic [5:0] rev6(input logic [5:0] v);
        return {v[0], v[1], v[2], v[3], v[4], v[5]};
    endfunction

    function automatic logic [5:0] sinv_raw(input logic [5:0] y);
        logic [5:0] r;
        r = 6'h00;
        case (y)
            6'h00: r = 6'h01;
            6'h01: r = 6'h0d;
            6'h02: r = 6'h20;
            6'h03: r = 6'h03;
            6'h04: r = 6'h0a;
            6'h05: r = 6'h1d;
            6'h06: r = 6'h21;
            6'h07: r = 6'h0b;
            6'h08: r = 6'h00;
            6'h09: r = 6'h02;
            6'h0a: r = 6'h28;
            6'h0b: r = 6'h22;
            6'h0c: r = 6'h08;
            6'h0d: r = 6'h09;
            6'h0e: r = 6'h2a;
            6'h0f: r = 6'h23;
            6'h10: r = 6'h05;
            6'h11: r = 6'h2d;
            6'h12: r = 6'h11;
            6'h13: r = 6'h07;
            6'h14: r = 6'h1a;
            6'h15: r = 6'h27;
            6'h16: r = 6'h15;
            6'h17: r = 6'h25;
            6'h18: r = 6'h12;
            6'h19: r = 6'h3d;
            6'h1a: r = 6'h10;
            6'h1b: r = 6'h29;
            6'h1c: r = 6'h18;
            6'h1d: r = 6'h19;
            6'h1e: r = 6'h35;
            6'h1f: r = 6'h2b;
            6'h20: r = 6'h0e;
            6'h21: r = 6'h26;
            6'h22: r = 6'h30;
            6'h23: r = 6'h0f;
            6'h24: r = 6'h1e;
            6'h25: r = 6'h2e;
            6'h26: r = 6'h31;
            6'h27: r = 6'h1f;
            6'h28: r = 6'h36;
            6'h29: r = 6'h06;
            6'h2a: r = 6'h32;
            6'h2b: r = 6'h38;
            6'h2c: r = 6'h16;
            6'h2d: r = 6'h3e;
            6'h2e: r = 6'h33;
            6'h2f: r = 6'h3a;
            6'h30: r = 6'h0c;
            6'h31: r = 6'h2c;
            6'h32: r = 6'h13;
            6'h33: r = 6'h24;
            6'h34: r = 6'h1c;
            6'h35: r = 6'h2f;
            6'h36: r = 6'h17;
            6'h37: r = 6'h1b;
            6'h38: r = 6'h04;
            6'h39: r = 6'h3c;
            6'h3a: r = 6'h34;
            6'h3b: r = 6'h39;
            6'h3c: r = 6'h37;
            6'h3d: r = 6'h3f;
            6'h3e: r = 6'h14;
            6'h3f: r = 6'h3b;
            default: r = 6'h00;
        endcase
        return r;
    endfunction

    function automatic logic [5:0] sinv(input logic [5:0] y);
        return rev6(sinv_raw(rev6(y)));
    endfunction

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [6*LANES-1:0] r_st;
    logic [CHW-1:0]     w_chunk;
    logic [CHW-1:0]     w_sub;

    always_comb begin
        w_chunk = '0;
        for (int c = 0; c < NCYC; c++) begin
            if (r_cnt == CW'(c)) begin
                w_chunk = r_st[c*CHW +: CHW];
            end
        end
    end

    for (genvar j = 0; j < PER_CYCLE; j++) begin : g_sbox
        assign w_sub[6*j +: 6] = sinv(w_chunk[6*j +: 6]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_st    <= '0;
        end else if (clr) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_st    <= in_data;
                        r_cnt   <= '0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    for (int c = 0; c < NCYC; c++) begin
                        if (r_cnt == CW'(c)) begin
                            r_st[c*CHW +: CHW] <= w_sub;
                        end
                    end
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out_data  = r_st;

endmodule
